sc_mmio_datamem: RTL and testbench
==================================

# sc_mmio_datamem

Data-side memory stage for the single-cycle CPU: consumes the CPU's ALU address, store data and write strobe and returns load data in the same cycle. The lower half of the address space is a word RAM; the upper half holds memory-mapped I/O: a free-running compare timer with an interrupt, and a byte transmit port backed by a small FIFO with a valid/ready handshake to an external sink. It replaces the plain data memory on the CPU's data bus without any change to the CPU.

## Interface
- RAM_WORDS, 32: RAM depth in 32-bit words (power of 2).
- FIFO_DEPTH, 4: TX FIFO entries (power of 2, ≥2).
- clk  in  1  clock; all state changes on the rising edge.
- clr  in  1  reset; one clock, reset is synchronous and active-high.
- addr  in  32  byte address from the CPU ALU output; addr[1:0] ignored.
- datain  in  32  store data.
- we  in  1  store strobe; writes on the rising edge when high.
- dataout  out  32  load data, combinational from addr and current state.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO not empty.
- tx_ready  in  1  sink accepts head when tx_valid && tx_ready at the edge.
- irq  out  1  timer interrupt pending (registered).

## Operation
- Decode: addr[31]=0 → RAM word addr[log2(RAM_WORDS)+1:2], upper bits aliased. addr[31]=1 → I/O, offset addr[4:2].
- I/O map (offsets): 0x00 COUNT (rw), 0x04 COMPARE (rw), 0x08 CTRL (bit0 EN rw, bit1 PEND read / write-1-to-clear), 0x10 TXDATA (write pushes datain[7:0]; reads 0), 0x14 STATUS (read: bit0 full, bit1 empty, bit2 overflow sticky, bits[7:4] occupancy; any write clears overflow). Other offsets: read 0, writes ignored.
- Timer: when EN, COUNT increments each cycle; if COUNT==COMPARE with EN, next COUNT=0 and PEND set. 32-bit wrap from 0xFFFFFFFF to 0 without setting PEND unless COMPARE matches.
- Priority: CPU write to COUNT beats increment/reload; PEND set by match beats a same-cycle W1C; EN cleared stops counting from the next cycle.
- irq = PEND.
- FIFO: push on TXDATA write if !full or a pop happens the same edge; otherwise byte dropped and overflow set. Pop on tx_valid && tx_ready. Simultaneous push+pop on empty not possible (tx_valid=0); on full: occupancy unchanged, new byte enters tail.
- tx_data holds while tx_valid && !tx_ready.
- RAM contents are not reset.

## Timing
- Loads: zero latency, combinational; STATUS/COUNT read in a cycle show pre-edge values (a same-cycle write is not visible).
- Stores: visible to loads in the cycle after the edge.
- Reset values: COUNT 0, COMPARE 0xFFFFFFFF, EN 0, PEND 0, irq 0, FIFO empty, tx_valid 0, tx_data 0, overflow 0, occupancy 0. dataout for RAM addresses reflects unreset RAM.
- clr asserted mid-transfer: FIFO flushed, an un-accepted head is discarded; clr dominates we on the same edge.
- Pushed byte appears on tx_data/tx_valid the cycle after the write if FIFO was empty.

## Structure
- Package sc_mmio_pkg: I/O offset constants, CTRL/STATUS bit positions, COMPARE reset value.
- Sub-module sc_tx_fifo (parameterised depth, push/pop/full/empty/count, overflow flag kept in the parent).
- Timer, decode and read mux in the top module.

## Test plan
- Reset, then store 0x12345678 to 0x0000_0010, load 0x0000_0010 next cycle → 0x12345678; load 0x0000_0090 (RAM_WORDS=32 alias) → 0x12345678.
- Write COMPARE=3, CTRL=1 → COUNT 0,1,2,3,0; PEND/irq rise the cycle COUNT returns to 0; write CTRL=0x3 → PEND stays 0 only if no match that edge, EN stays 1.
- Hold tx_ready=0, write TXDATA 0xA1..0xA5 → STATUS occupancy 4, full=1, overflow=1; raise tx_ready → bytes A1,A2,A3,A4 one per cycle, then tx_valid=0.
- FIFO full, TXDATA write 0xB0 with tx_ready=1 same edge → head popped, 0xB0 accepted, occupancy stays 4, overflow unchanged.
- Timer running and FIFO holding 2 bytes, assert clr for 1 cycle → COUNT 0, irq 0, tx_valid 0, COMPARE 0xFFFFFFFF; RAM word written before reset still reads back.
- Load 0x8000_001C (unmapped) → 0; write there → no register changes.

Source files
------------

// File: rtl/sc_mmio_pkg.sv
// sc_mmio_pkg: I/O offsets, register bit positions and reset constants for sc_mmio_datamem
package sc_mmio_pkg;
    localparam logic [2:0] OFF_COUNT   = 3'd0;
    localparam logic [2:0] OFF_COMPARE = 3'd1;
    localparam logic [2:0] OFF_CTRL    = 3'd2;
    localparam logic [2:0] OFF_TXDATA  = 3'd4;
    localparam logic [2:0] OFF_STATUS  = 3'd5;
    localparam int CTRL_EN   = 0;
    localparam int CTRL_PEND = 1;
    localparam int ST_FULL   = 0;
    localparam int ST_EMPTY  = 1;
    localparam int ST_OVF    = 2;
    localparam int ST_OCC    = 4;
    localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;
endpackage

// File: rtl/sc_mmio_datamem_if.sv
// sc_mmio_datamem_if: CPU data bus plus TX sink handshake and timer interrupt
interface sc_mmio_datamem_if;
    logic [31:0] addr;
    logic [31:0] datain;
    logic [31:0] dataout;
    logic        we;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        irq;
    modport master (output addr, datain, we, tx_ready, input dataout, tx_data, tx_valid, irq);
    modport slave  (input addr, datain, we, tx_ready, output dataout, tx_data, tx_valid, irq);
endinterface

// File: rtl/sc_tx_fifo.sv
// sc_tx_fifo: byte FIFO for the transmit port; head reads 0 when empty
module sc_tx_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [7:0]    data_i,
    output logic [7:0]    data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0]   cnt_q;
    always_ff @(posedge clk) begin
        if (clr) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (pop_i) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end
    always_ff @(posedge clk) begin
        if (!clr && push_i) mem_q[wr_q] <= data_i;
    end
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign count_o = cnt_q;
    assign data_o  = empty_o ? 8'h00 : mem_q[rd_q];
endmodule

// File: rtl/sc_mmio_datamem.sv
// sc_mmio_datamem: word RAM in the lower half, compare timer and TX FIFO mapped in the upper half
module sc_mmio_datamem
    import sc_mmio_pkg::*;
#(
    parameter int RAM_WORDS  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input logic clk,
    input logic clr,
    sc_mmio_datamem_if.slave bus
);
    localparam int RA = $clog2(RAM_WORDS);
    localparam int FA = $clog2(FIFO_DEPTH);
    logic [31:0] ram_q [RAM_WORDS];
    logic [31:0] count_q, count_d, compare_q, compare_d, ctrl, status, io_rd;
    logic        en_q, en_d, pend_q, pend_d, ovf_q, ovf_d;
    logic        io, match, push, pop, full, empty, unused_addr;
    logic        wr_count, wr_compare, wr_ctrl, wr_tx, wr_status;
    logic [2:0]  off;
    logic [FA:0] occ;
    assign io          = bus.addr[31];
    assign off         = bus.addr[4:2];
    assign unused_addr = ^bus.addr;
    assign wr_count    = bus.we && io && off == OFF_COUNT;
    assign wr_compare  = bus.we && io && off == OFF_COMPARE;
    assign wr_ctrl     = bus.we && io && off == OFF_CTRL;
    assign wr_tx       = bus.we && io && off == OFF_TXDATA;
    assign wr_status   = bus.we && io && off == OFF_STATUS;
    assign match       = en_q && count_q == compare_q;
    assign pop         = !empty && bus.tx_ready;
    // a full FIFO still takes the byte when its head leaves on the same edge
    assign push        = wr_tx && (!full || pop);
    always_comb begin
        count_d   = wr_count ? bus.datain : match ? 32'd0 : en_q ? count_q + 32'd1 : count_q;
        compare_d = wr_compare ? bus.datain : compare_q;
        en_d      = wr_ctrl ? bus.datain[CTRL_EN] : en_q;
        pend_d    = match || (pend_q && !(wr_ctrl && bus.datain[CTRL_PEND]));
        ovf_d     = wr_status ? 1'b0 : ovf_q || (wr_tx && !push);
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            count_q   <= '0;
            compare_q <= COMPARE_RST;
            en_q      <= 1'b0;
            pend_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            en_q      <= en_d;
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
        end
    end
    always_ff @(posedge clk) begin
        if (!clr && bus.we && !io) ram_q[bus.addr[RA+1:2]] <= bus.datain;
    end
    sc_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .clr     (clr),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (bus.datain[7:0]),
        .data_o  (bus.tx_data),
        .full_o  (full),
        .empty_o (empty),
        .count_o (occ)
    );
    always_comb begin
        ctrl                = '0;
        ctrl[CTRL_EN]       = en_q;
        ctrl[CTRL_PEND]     = pend_q;
        status              = '0;
        status[ST_FULL]     = full;
        status[ST_EMPTY]    = empty;
        status[ST_OVF]      = ovf_q;
        status[ST_OCC+:4]   = 4'(occ);
        io_rd = off == OFF_COUNT   ? count_q :
                off == OFF_COMPARE ? compare_q :
                off == OFF_CTRL    ? ctrl :
                off == OFF_STATUS  ? status : 32'd0;
    end
    assign bus.dataout  = io ? io_rd : ram_q[bus.addr[RA+1:2]];
    assign bus.tx_valid = !empty;
    assign bus.irq      = pend_q;
endmodule

// File: tb/tb_sc_mmio_datamem.sv
// tb_sc_mmio_datamem: directed scenarios plus random traffic against a behavioural model
module tb_sc_mmio_datamem;
    logic clk = 1'b0;
    logic clr;
    int n_cmp = 0;
    int n_bad = 0;
    sc_mmio_datamem_if bus();
    sc_mmio_datamem #(.RAM_WORDS(32), .FIFO_DEPTH(4)) dut (.clk(clk), .clr(clr), .bus(bus));
    always #5 clk = ~clk;

    // behavioural model: RAM array, timer variables, FIFO as a queue
    logic [31:0] m_ram [32];
    logic [31:0] m_count, m_cmp;
    logic        m_en, m_pend, m_ovf;
    logic [7:0]  m_q [$];

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (!a[31]) return m_ram[a[6:2]];
        case (a[4:2])
            3'd0: return m_count;
            3'd1: return m_cmp;
            3'd2: return {30'd0, m_pend, m_en};
            3'd5: return {24'd0, 4'(m_q.size()), 1'b0, m_ovf, m_q.size() == 0, m_q.size() == 4};
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_step;
        logic io, w, pop, full, hit;
        logic [2:0] off;
        logic [31:0] d, nc;
        if (clr) begin
            m_count = 0; m_cmp = 32'hFFFF_FFFF; m_en = 0; m_pend = 0; m_ovf = 0;
            m_q.delete();
            return;
        end
        io = bus.addr[31]; off = bus.addr[4:2]; w = bus.we; d = bus.datain;
        pop  = m_q.size() > 0 && bus.tx_ready;
        full = m_q.size() == 4;
        hit  = m_en && m_count == m_cmp;
        nc = (w && io && off == 0) ? d : hit ? 32'd0 : m_en ? m_count + 1 : m_count;
        m_pend = hit || (m_pend && !(w && io && off == 2 && d[1]));
        m_count = nc;
        if (w && io && off == 1) m_cmp = d;
        if (w && io && off == 2) m_en = d[0];
        if (pop) void'(m_q.pop_front());
        if (w && io && off == 4) begin
            if (!full || pop) m_q.push_back(d[7:0]);
            else m_ovf = 1;
        end
        if (w && io && off == 5) m_ovf = 0;
        if (w && !io) m_ram[bus.addr[6:2]] = d;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
        bus.addr = a; bus.datain = d; bus.we = w; bus.tx_ready = r;
        #1;
    endtask

    task automatic adv;
        @(posedge clk);
        m_step();
        @(negedge clk);
    endtask

    task automatic test_reset;
        clr = 1'b1;
        drive(32'h8000_0000, 32'h0, 1'b0, 1'b0);
        adv();
        clr = 1'b0;
        drive(32'h8000_0000, 0, 0, 0);
        n_cmp++; if (bus.dataout !== 32'h0) begin n_bad++; $display("FAIL reset_count got %h exp %h", bus.dataout, 32'h0); end
        n_cmp++; if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got %b exp 0", bus.irq); end
        n_cmp++; if (bus.tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid got %b exp 0", bus.tx_valid); end
        n_cmp++; if (bus.tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data got %h exp 00", bus.tx_data); end
        drive(32'h8000_0004, 0, 0, 0);
        n_cmp++; if (bus.dataout !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL reset_compare got %h exp ffffffff", bus.dataout); end
        drive(32'h8000_0008, 0, 0, 0);
        n_cmp++; if (bus.dataout !== 32'h0) begin n_bad++; $display("FAIL reset_ctrl got %h exp 0", bus.dataout); end
        drive(32'h8000_0014, 0, 0, 0);
        n_cmp++; if (bus.dataout !== 32'h2) begin n_bad++; $display("FAIL reset_status got %h exp 2", bus.dataout); end
    endtask

    task automatic test_ram;
        drive(32'h0000_0010, 32'h1234_5678, 1, 0);
        adv();
        drive(32'h0000_0010, 0, 0, 0);
        n_cmp++; if (bus.dataout !== 32'h1234_5678) begin n_bad++; $display("FAIL ram_load got %h exp 12345678", bus.dataout); end
        drive(32'h0000_0090, 0, 0, 0);
        n_cmp++; if (bus.dataout !== 32'h1234_5678) begin n_bad++; $display("FAIL ram_alias got %h exp 12345678", bus.dataout); end
        drive(32'h0000_0014, 32'hDEAD_BEEF, 1, 0);
        adv();
        drive(32'h0000_0010, 0, 0, 0);
        n_cmp++; if (bus.dataout !== 32'h1234_5678) begin n_bad++; $display("FAIL ram_neighbour got %h exp 12345678", bus.dataout); end
    endtask

    task automatic test_timer;
        logic [31:0] exp_c [5] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
        logic [31:0] exp_w [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1};
        logic        exp_i [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        drive(32'h8000_0004, 32'd3, 1, 0); adv();
        drive(32'h8000_0008, 32'd1, 1, 0); adv();
        for (int i = 0; i < 5; i++) begin
            drive(32'h8000_0000, 0, 0, 0);
            n_cmp++; if (bus.dataout !== exp_c[i]) begin n_bad++; $display("FAIL timer_count[%0d] got %h exp %h", i, bus.dataout, exp_c[i]); end
            n_cmp++; if (bus.irq !== exp_i[i]) begin n_bad++; $display("FAIL timer_irq[%0d] got %b exp %b", i, bus.irq, exp_i[i]); end
            adv();
        end
        drive(32'h8000_0008, 32'd3, 1, 0); adv();
        drive(32'h8000_0008, 0, 0, 0);
        n_cmp++; if (bus.dataout !== 32'h1) begin n_bad++; $display("FAIL timer_w1c got %h exp 1", bus.dataout); end
        n_cmp++; if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL timer_w1c_irq got %b exp 0", bus.irq); end
        adv();
        drive(32'h8000_0008, 32'd3, 1, 0); adv();
        drive(32'h8000_0008, 0, 0, 0);
        n_cmp++; if (bus.dataout !== 32'h3) begin n_bad++; $display("FAIL timer_set_beats_clear got %h exp 3", bus.dataout); end
        drive(32'h8000_0000, 0, 0, 0);
        n_cmp++; if (bus.dataout !== 32'h0) begin n_bad++; $display("FAIL timer_reload got %h exp 0", bus.dataout); end
        drive(32'h8000_0008, 32'd2, 1, 0); adv();
        drive(32'h8000_0004, 32'd5, 1, 0); adv();
        drive(32'h8000_0000, 32'hFFFF_FFFE, 1, 0); adv();
        drive(32'h8000_0008, 32'd1, 1, 0); adv();
        for (int i = 0; i < 4; i++) begin
            drive(32'h8000_0000, 0, 0, 0);
            n_cmp++; if (bus.dataout !== exp_w[i]) begin n_bad++; $display("FAIL timer_wrap[%0d] got %h exp %h", i, bus.dataout, exp_w[i]); end
            n_cmp++; if (bus.irq !== 1'b0) begin n_bad++; $display("FAIL timer_wrap_irq[%0d] got %b exp 0", i, bus.irq); end
            adv();
        end
        drive(32'h8000_0008, 32'd0, 1, 0); adv();
        drive(32'h8000_0000, 0, 0, 0);
        n_cmp++; if (bus.dataout !== 32'd3) begin n_bad++; $display("FAIL timer_stop got %h exp 3", bus.dataout); end
        adv();
        n_cmp++; if (bus.dataout !== 32'd3) begin n_bad++; $display("FAIL timer_held got %h exp 3", bus.dataout); end
    endtask

    task automatic test_fifo;
        for (int i = 0; i < 5; i++) begin
            drive(32'h8000_0010, 32'hA1 + i, 1, 0);
            n_cmp++; if (bus.tx_valid !== (i != 0)) begin n_bad++; $display("FAIL fifo_fill_valid[%0d] got %b exp %b", i, bus.tx_valid, i != 0); end
            if (i != 0) begin
                n_cmp++; if (bus.tx_data !== 8'hA1) begin n_bad++; $display("FAIL fifo_fill_head[%0d] got %h exp a1", i, bus.tx_data); end
            end
            adv();
        end
        drive(32'h8000_0014, 0, 0, 0);
        n_cmp++; if (bus.dataout !== 32'h45) begin n_bad++; $display("FAIL fifo_status_full got %h exp 45", bus.dataout); end
        drive(32'h8000_0010, 0, 0, 0);
        n_cmp++; if (bus.dataout !== 32'h0) begin n_bad++; $display("FAIL txdata_read got %h exp 0", bus.dataout); end
        for (int i = 0; i < 4; i++) begin
            drive(32'h0, 0, 0, 1);
            n_cmp++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'(8'hA1 + i)) begin
                n_bad++; $display("FAIL fifo_drain[%0d] got %b/%h exp 1/%h", i, bus.tx_valid, bus.tx_data, 8'(8'hA1 + i)); end
            adv();
        end
        n_cmp++; if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) begin n_bad++; $display("FAIL fifo_empty got %b/%h exp 0/00", bus.tx_valid, bus.tx_data); end
        drive(32'h8000_0014, 0, 1, 0); adv();
        drive(32'h8000_0014, 0, 0, 0);
        n_cmp++; if (bus.dataout !== 32'h2) begin n_bad++; $display("FAIL fifo_ovf_clear got %h exp 2", bus.dataout); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin drive(32'h8000_0010, 32'hC1 + i, 1, 0); adv(); end
        drive(32'h8000_0014, 0, 0, 0);
        n_cmp++; if (bus.dataout !== 32'h41) begin n_bad++; $display("FAIL b2b_status_pre got %h exp 41", bus.dataout); end
        drive(32'h8000_0010, 32'hB0, 1, 1);
        n_cmp++; if (bus.tx_data !== 8'hC1) begin n_bad++; $display("FAIL b2b_head got %h exp c1", bus.tx_data); end
        adv();
        drive(32'h8000_0014, 0, 0, 0);
        n_cmp++; if (bus.dataout !== 32'h41) begin n_bad++; $display("FAIL b2b_status_post got %h exp 41", bus.dataout); end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] e;
            e = (i == 3) ? 8'hB0 : 8'(8'hC2 + i);
            drive(32'h0, 0, 0, 1);
            n_cmp++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== e) begin n_bad++; $display("FAIL b2b_drain[%0d] got %b/%h exp 1/%h", i, bus.tx_valid, bus.tx_data, e); end
            adv();
        end
    endtask

    task automatic test_clr;
        drive(32'h0000_0020, 32'hCAFE_F00D, 1, 0); adv();
        drive(32'h8000_0004, 32'd7, 1, 0); adv();
        drive(32'h8000_0000, 32'd0, 1, 0); adv();
        drive(32'h8000_0008, 32'd1, 1, 0); adv();
        drive(32'h8000_0010, 32'h11, 1, 0); adv();
        drive(32'h8000_0010, 32'h22, 1, 0); adv();
        for (int i = 0; i < 8; i++) begin drive(32'h0, 0, 0, 0); adv(); end
        n_cmp++; if (bus.irq !== 1'b1 || bus.tx_valid !== 1'b1) begin n_bad++; $display("FAIL clr_pre got irq %b valid %b exp 1 1", bus.irq, bus.tx_valid); end
        clr = 1'b1;
        drive(32'h8000_0000, 32'h55, 1, 0);
        adv();
        clr = 1'b0;
        drive(32'h8000_0000, 0, 0, 0);
        n_cmp++; if (bus.dataout !== 32'h0) begin n_bad++; $display("FAIL clr_count got %h exp 0", bus.dataout); end
        n_cmp++; if (bus.irq !== 1'b0 || bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) begin
            n_bad++; $display("FAIL clr_outputs got irq %b valid %b data %h exp 0 0 00", bus.irq, bus.tx_valid, bus.tx_data); end
        drive(32'h8000_0004, 0, 0, 0);
        n_cmp++; if (bus.dataout !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL clr_compare got %h exp ffffffff", bus.dataout); end
        drive(32'h8000_0014, 0, 0, 0);
        n_cmp++; if (bus.dataout !== 32'h2) begin n_bad++; $display("FAIL clr_status got %h exp 2", bus.dataout); end
        drive(32'h0000_0020, 0, 0, 0);
        n_cmp++; if (bus.dataout !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL clr_ram got %h exp cafef00d", bus.dataout); end
    endtask

    task automatic test_unmapped;
        logic [31:0] regs [4] = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_0014};
        logic [31:0] expv [4] = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h2};
        drive(32'h8000_001C, 0, 0, 0);
        n_cmp++; if (bus.dataout !== 32'h0) begin n_bad++; $display("FAIL unmapped_1c got %h exp 0", bus.dataout); end
        drive(32'h8000_000C, 0, 0, 0);
        n_cmp++; if (bus.dataout !== 32'h0) begin n_bad++; $display("FAIL unmapped_0c got %h exp 0", bus.dataout); end
        drive(32'h8000_001C, 32'hFFFF_FFFF, 1, 0); adv();
        drive(32'h8000_000C, 32'hFFFF_FFFF, 1, 0); adv();
        for (int i = 0; i < 4; i++) begin
            drive(regs[i], 0, 0, 0);
            n_cmp++; if (bus.dataout !== expv[i]) begin n_bad++; $display("FAIL unmapped_effect[%0d] got %h exp %h", i, bus.dataout, expv[i]); end
        end
    endtask

    task automatic test_random;
        logic [31:0] a, d, e;
        for (int i = 0; i < 32; i++) begin drive(32'(i * 4), $urandom, 1, 0); adv(); end
        for (int n = 0; n < 600; n++) begin
            a = $urandom;
            a[31] = $urandom_range(0, 1) == 1;
            if (a[31] && $urandom_range(0, 1) == 1) a[4:2] = 3'($urandom_range(0, 2));
            d = (a[31] && a[4:2] <= 1) ? 32'($urandom_range(0, 12)) : $urandom;
            clr = $urandom_range(0, 59) == 0;
            drive(a, d, $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0);
            e = m_read(a);
            n_cmp++; if (bus.dataout !== e) begin n_bad++; $display("FAIL rnd_dataout[%0d] addr %h got %h exp %h", n, a, bus.dataout, e); end
            n_cmp++; if (bus.tx_valid !== (m_q.size() != 0)) begin n_bad++; $display("FAIL rnd_tx_valid[%0d] got %b exp %b", n, bus.tx_valid, m_q.size() != 0); end
            n_cmp++; if (bus.tx_data !== (m_q.size() != 0 ? m_q[0] : 8'h00)) begin
                n_bad++; $display("FAIL rnd_tx_data[%0d] got %h exp %h", n, bus.tx_data, m_q.size() != 0 ? m_q[0] : 8'h00); end
            n_cmp++; if (bus.irq !== m_pend) begin n_bad++; $display("FAIL rnd_irq[%0d] got %b exp %b", n, bus.irq, m_pend); end
            adv();
            clr = 1'b0;
        end
    endtask

    initial begin
        clr = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_ram();
        test_timer();
        test_fifo();
        test_back_to_back();
        test_clr();
        test_unmapped();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
